// File: rtl/jogo_sequencia_param.sv
// jogo_sequencia_param: Simon-style memory game with an internal sequence RAM.
// Optional feature macro: SEQ_ESCRITA_JOGADOR_EN (dynamic mode, where the player's
// last press of each round is appended to the RAM instead of being checked).
// Ports:
//   clock, reset              system clock, asynchronous active-low reset
//   jogar                     start/restart pulse (INICIAL, FIM_GANHOU, FIM_PERDEU only)
//   configuracao              bit0 demo (4 rounds), bit1 timeout enable; latched at start
//   botoes                    synchronised button levels
//   esc_en, esc_end, esc_dado sequence RAM preload port, honoured only in INICIAL
//   leds                      displayed item or echo of the registered press
//   pronto, ganhou, perdeu    end-of-game flags
//   timeout                   loss was caused by the play timer
//   db_rodada, db_estado      debug: round index and state encoding
module jogo_sequencia_param #(
    parameter int NUM_BOTOES     = 4,
    parameter int PROF           = 16,
    parameter int EXIBE_CICLOS   = 500,
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    jogar,
    input  logic [1:0]              configuracao,
    input  logic [NUM_BOTOES-1:0]   botoes,
    input  logic                    esc_en,
    input  logic [$clog2(PROF)-1:0] esc_end,
    input  logic [NUM_BOTOES-1:0]   esc_dado,
    output logic [NUM_BOTOES-1:0]   leds,
    output logic                    pronto,
    output logic                    ganhou,
    output logic                    perdeu,
    output logic                    timeout,
    output logic [$clog2(PROF)-1:0] db_rodada,
    output logic [3:0]              db_estado
);
    localparam int AW = $clog2(PROF);
    localparam int EW = EXIBE_CICLOS > 1 ? $clog2(EXIBE_CICLOS) : 1;
    localparam int TW = TIMEOUT_CICLOS > 1 ? $clog2(TIMEOUT_CICLOS) : 1;
`ifdef SEQ_ESCRITA_JOGADOR_EN
    localparam bit DINAMICO = 1'b1;
`else
    localparam bit DINAMICO = 1'b0;
`endif

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        MOSTRA      = 4'd2,
        APAGA       = 4'd3,
        ESPERA      = 4'd4,
        REGISTRA    = 4'd5,
        COMPARA     = 4'd6,
        PROX_JOGADA = 4'd7,
        PROX_RODADA = 4'd8,
        FIM_GANHOU  = 4'd9,
        FIM_PERDEU  = 4'd10
    } estado_t;

    estado_t               estado_q, estado_d;
    logic [AW-1:0]         rodada_q, rodada_d, item_q, item_d, jogada_q, jogada_d;
    logic [EW-1:0]         cnt_exib_q, cnt_exib_d;
    logic [TW-1:0]         cnt_to_q, cnt_to_d;
    logic [NUM_BOTOES-1:0] botoes_ant_q, cap_q, cap_d;
    logic                  invalida_q, invalida_d, to_q, to_d;
    logic [1:0]            config_q, config_d;
    logic [NUM_BOTOES-1:0] mem_q [PROF];

    logic [NUM_BOTOES-1:0] borda, mem_dado;
    logic [AW-1:0]         limite, mem_end;
    logic                  inicio, fim_exib, ultimo_item, expirou, anexa, acerto, mem_we;

    always_comb begin
        borda       = botoes & ~botoes_ant_q;
        limite      = config_q[0] ? AW'(3) : AW'(PROF - 1);
        inicio      = jogar && (estado_q == INICIAL || estado_q == FIM_GANHOU || estado_q == FIM_PERDEU);
        fim_exib    = cnt_exib_q == EW'(EXIBE_CICLOS - 1);
        // in dynamic mode the newest item of the round is not shown, the player supplies it
        ultimo_item = DINAMICO ? (AW+1)'(item_q) + (AW+1)'(1) >= (AW+1)'(rodada_q) : item_q >= rodada_q;
        expirou     = config_q[1] && cnt_to_q == TW'(TIMEOUT_CICLOS - 1);
        anexa       = DINAMICO && jogada_q == rodada_q;
        acerto      = !invalida_q && (anexa || cap_q == mem_q[jogada_q]);
        mem_we      = (esc_en && estado_q == INICIAL) || (estado_q == COMPARA && anexa && !invalida_q);
        mem_end     = estado_q == INICIAL ? esc_end : rodada_q;
        mem_dado    = estado_q == INICIAL ? esc_dado : cap_q;
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem_q[mem_end] <= mem_dado;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= INICIAL;
            rodada_q     <= '0;
            item_q       <= '0;
            jogada_q     <= '0;
            cnt_exib_q   <= '0;
            cnt_to_q     <= '0;
            botoes_ant_q <= '0;
            cap_q        <= '0;
            invalida_q   <= 1'b0;
            to_q         <= 1'b0;
            config_q     <= '0;
        end else begin
            estado_q     <= estado_d;
            rodada_q     <= rodada_d;
            item_q       <= item_d;
            jogada_q     <= jogada_d;
            cnt_exib_q   <= cnt_exib_d;
            cnt_to_q     <= cnt_to_d;
            botoes_ant_q <= botoes;
            cap_q        <= cap_d;
            invalida_q   <= invalida_d;
            to_q         <= to_d;
            config_q     <= config_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL, FIM_GANHOU, FIM_PERDEU: estado_d = jogar ? PREPARA : estado_q;
            PREPARA:     estado_d = (DINAMICO && rodada_q == '0) ? ESPERA : MOSTRA;
            MOSTRA:      estado_d = fim_exib ? APAGA : MOSTRA;
            APAGA:       estado_d = !fim_exib ? APAGA : ultimo_item ? ESPERA : MOSTRA;
            // a press in the expiry cycle still counts as a play
            ESPERA:      estado_d = |borda ? REGISTRA : expirou ? FIM_PERDEU : ESPERA;
            REGISTRA:    estado_d = COMPARA;
            COMPARA:     estado_d = !acerto ? FIM_PERDEU : jogada_q != rodada_q ? PROX_JOGADA :
                                    rodada_q == limite ? FIM_GANHOU : PROX_RODADA;
            PROX_JOGADA: estado_d = ESPERA;
            PROX_RODADA: estado_d = PREPARA;
            default:     estado_d = INICIAL;
        endcase
    end

    always_comb begin
        rodada_d   = inicio ? '0 : estado_q == PROX_RODADA ? rodada_q + AW'(1) : rodada_q;
        item_d     = estado_q == PREPARA ? '0 :
                     (estado_q == APAGA && fim_exib && !ultimo_item) ? item_q + AW'(1) : item_q;
        jogada_d   = estado_q == PREPARA ? '0 : estado_q == PROX_JOGADA ? jogada_q + AW'(1) : jogada_q;
        cnt_exib_d = ((estado_q == MOSTRA || estado_q == APAGA) && !fim_exib) ? cnt_exib_q + EW'(1) : '0;
        // cleared in every other state, so each entry into ESPERA starts from zero
        cnt_to_d   = (estado_q == ESPERA && config_q[1]) ? cnt_to_q + TW'(1) : '0;
        cap_d      = (estado_q == ESPERA && |borda) ? borda : cap_q;
        invalida_d = (estado_q == ESPERA && |borda) ? !$onehot(borda) : invalida_q;
        to_d       = inicio ? 1'b0 : (estado_q == ESPERA && !(|borda) && expirou) ? 1'b1 : to_q;
        config_d   = inicio ? configuracao : config_q;
    end

    always_comb begin
        leds      = estado_q == MOSTRA ? mem_q[item_q] : estado_q == REGISTRA ? cap_q : '0;
        ganhou    = estado_q == FIM_GANHOU;
        perdeu    = estado_q == FIM_PERDEU;
        pronto    = estado_q == FIM_GANHOU || estado_q == FIM_PERDEU;
        timeout   = estado_q == FIM_PERDEU && to_q;
        db_rodada = rodada_q;
        db_estado = estado_q;
    end
endmodule

// File: doc/jogo_sequencia_param.md
Name: jogo_sequencia_param

Overview:
- Parametrised successor to the memory-game datapath/controller pair, packaged as a single block with an internal sequence RAM.
- Simon-style game: round r replays sequence items 0..r on leds, then checks player presses 0..r. Supports N buttons, sequence depth and per-play timeout.
- Sits between the board button debouncers and the LED and seven-segment drivers.
- Clock is 1 kHz in the top level.

Parameters:
- NUM_BOTOES, 4, button/LED count; sequence items are one-hot of this width.
- PROF, 16, sequence memory depth (maximum rounds); must be ≥ 4.
- EXIBE_CICLOS, 500, cycles each LED item is lit; an equal gap follows each item.
- TIMEOUT_CICLOS, 5000, cycles allowed per play before timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- jogar  in  1  start pulse; sampled only in INICIAL, FIM_GANHOU, FIM_PERDEU
- configuracao  in  2  bit0: 1 = demo (limit 4 rounds), 0 = full (PROF rounds); bit1: 1 = timeout enabled. Latched on accepted jogar.
- botoes  in  NUM_BOTOES  button levels, already synchronised
- esc_en  in  1  sequence RAM write enable; honoured only in INICIAL
- esc_end  in  $clog2(PROF)  write address
- esc_dado  in  NUM_BOTOES  write data
- leds  out  NUM_BOTOES  item display / echo of pressed button
- pronto  out  1  high in FIM_GANHOU or FIM_PERDEU
- ganhou  out  1  high in FIM_GANHOU
- perdeu  out  1  high in FIM_PERDEU
- timeout  out  1  high in FIM_PERDEU when loss was by timeout
- db_rodada  out  $clog2(PROF)  current round index
- db_estado  out  4  state encoding

Behaviour:
- Reset (reset=0, async): state INICIAL; all outputs 0; round, play, display and timeout counters 0. RAM contents are not cleared.
- Reset mid-game aborts immediately with no end flags.
- Play edge: rising edge of any botoes bit (registered previous value). A valid play is exactly one new bit set; multiple simultaneous new bits count as a wrong play.
- Limit L = 3 if latched bit0 = 1, else PROF-1.
- State INICIAL (0): wait for jogar; then latch configuracao and clear round → PREPARA.
- State PREPARA (1): clear item index → MOSTRA.
- State MOSTRA (2): leds = RAM[item] for EXIBE_CICLOS cycles → APAGA.
- State APAGA (3): leds = 0 for EXIBE_CICLOS cycles.
  - If item < round: increment item → MOSTRA.
  - Else: clear play index and timeout counter → ESPERA.
- State ESPERA (4): timeout counter increments each cycle when bit1 = 1.
  - Valid or invalid play edge → REGISTRA.
  - Counter reaching TIMEOUT_CICLOS-1 → FIM_PERDEU with timeout = 1.
  - A play edge in the same cycle as expiry wins; the play is accepted.
- State REGISTRA (5): capture the edge, leds echo it for 1 cycle → COMPARA.
- State COMPARA (6): compare capture with RAM[play].
  - Mismatch → FIM_PERDEU.
  - Match and play < round → PROX_JOGADA.
  - Match and play == round: round == L → FIM_GANHOU, else → PROX_RODADA.
- State PROX_JOGADA (7): play + 1; timeout counter cleared → ESPERA.
- State PROX_RODADA (8): round + 1 → PREPARA.
- State FIM_GANHOU (9) / FIM_PERDEU (10): flags hold; leds = 0.
  - jogar restarts: flags clear on the transition, fresh configuracao latched → PREPARA.
- Presses during MOSTRA/APAGA are ignored; the edge register is still updated so held buttons do not trigger later.
- RAM read is combinational from the registered index; no read latency is exposed.
- Counters are sized $clog2 of their maximum; round never wraps because L ≤ PROF-1.
- esc_en outside INICIAL is ignored.

Optional Feature:
- Macro SEQ_ESCRITA_JOGADOR_EN.
- Defined:
  - Dynamic mode. Rounds 1..L begin without MOSTRA for the new last item. At play == round, COMPARA writes the captured press into RAM[round] instead of comparing (always a match). A multi-bit press is still a loss.
  - Round 0 writes RAM[0] from the first press, skipping display.
  - esc_* ports remain but only preload.
- Undefined: sequence fixed by preload; writes never occur during play.

Test Plan:
- Preload RAM[0..3] = 0001, 0010, 0100, 1000; configuracao = 01; press the correct sequence each round → ganhou = 1 and pronto = 1 after round 3; perdeu = 0; db_rodada = 3.
- Same preload; at round 2, play 1, press 1000 → perdeu = 1, timeout = 0, in the cycle after COMPARA.
- configuracao = 11; after round-0 display, no press → after exactly TIMEOUT_CICLOS cycles in ESPERA: perdeu = 1, timeout = 1. With bit1 = 0, wait 10000 cycles → still ESPERA.
- Press 0011 simultaneously at play 0 → perdeu = 1. Press during MOSTRA, held into ESPERA → no play registered.
- Assert reset = 0 mid-ESPERA → INICIAL immediately, outputs 0. Then jogar → game restarts with RAM intact.
- With SEQ_ESCRITA_JOGADOR_EN, configuracao = 01: press 0100, then 0100, 0001, then 0100, 0001, 1000, then 0100, 0001, 1000, 0010 → ganhou = 1; RAM[0..3] = 0100, 0001, 1000, 0010.
